// File: rtl/aemb_intc.sv
// AEMB interrupt controller: synchronises up to 32 rising-edge sources, latches them as
// pending, masks them into one registered interrupt level, and exposes STAT/MASK/ACK/VEC on Wishbone.
module aemb_intc #(
  parameter int NSRC = 8
) (
  input  logic            gclk,
  input  logic            grst,
  input  logic [NSRC-1:0] irq_i,
  output logic            sys_int_o,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  output logic            wb_ack_o
);

  localparam logic [1:0] ADR_STAT = 2'd0;
  localparam logic [1:0] ADR_MASK = 2'd1;
  localparam logic [1:0] ADR_ACK  = 2'd2;
  localparam logic [1:0] ADR_VEC  = 2'd3;

  logic [NSRC-1:0] rsyn1_q, rsyn2_q, rprev_q;
  logic [NSRC-1:0] rpend_q, rpend_d;
  logic [NSRC-1:0] rmask_q, rmask_d;
  logic            sys_int_q;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;

  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] ack_clr;
  logic            xfer;
  logic            wr;
  logic            unused_dat;

  function automatic logic [31:0] widen(input logic [NSRC-1:0] x);
    logic [31:0] w;
    w = '0;
    w[NSRC-1:0] = x;
    return w;
  endfunction

  // Walk downward so the lowest active index is the last one written and therefore wins.
  function automatic logic [31:0] vec_word(input logic [NSRC-1:0] act);
    logic [31:0] v;
    v = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) v = {1'b1, 26'd0, 5'(i)};
    end
    return v;
  endfunction

  assign unused_dat = ^wb_dat_i;
  assign edge_det   = rsyn2_q & ~rprev_q;

  always_comb begin
    xfer    = wb_stb_i & ~ack_q;
    wr      = xfer & wb_we_i;
    ack_d   = xfer;
    rmask_d = rmask_q;
    ack_clr = '0;
    dat_d   = '0;
    if (wr && wb_adr_i == ADR_MASK) rmask_d = wb_dat_i[NSRC-1:0];
    if (wr && wb_adr_i == ADR_ACK)  ack_clr = wb_dat_i[NSRC-1:0];
    // A new edge in the same cycle as its acknowledge keeps the bit set.
    rpend_d = (rpend_q & ~ack_clr) | edge_det;
    if (xfer && !wb_we_i) begin
      unique case (wb_adr_i)
        ADR_STAT: dat_d = widen(rpend_q);
        ADR_MASK: dat_d = widen(rmask_q);
        ADR_ACK:  dat_d = '0;
        ADR_VEC:  dat_d = vec_word(rpend_q & rmask_q);
        default:  dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (!grst) begin
      rsyn1_q   <= '0;
      rsyn2_q   <= '0;
      rprev_q   <= '0;
      rpend_q   <= '0;
      rmask_q   <= '0;
      sys_int_q <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      rsyn1_q   <= irq_i;
      rsyn2_q   <= rsyn1_q;
      rprev_q   <= rsyn2_q;
      rpend_q   <= rpend_d;
      rmask_q   <= rmask_d;
      sys_int_q <= |(rpend_q & rmask_q);
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  assign sys_int_o = sys_int_q;
  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_aemb_intc.sv
// Scoreboard bench for aemb_intc: a cycle-level reference model queues expected bus
// responses and interrupt levels; a negedge monitor pops and compares them.
module tb_aemb_intc;
  localparam int NSRC = 8;

  logic            gclk = 1'b0;
  logic            grst = 1'b0;
  logic [NSRC-1:0] irq = '0;
  logic            stb = 1'b0;
  logic            we = 1'b0;
  logic [1:0]      adr = '0;
  logic [31:0]     dati = '0;
  logic            sys_int;
  logic [31:0]     dato;
  logic            ack;

  aemb_intc #(.NSRC(NSRC)) dut (
    .gclk(gclk), .grst(grst), .irq_i(irq), .sys_int_o(sys_int),
    .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dati),
    .wb_dat_o(dato), .wb_ack_o(ack)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: irq samples at the last three edges, pending set, mask, expected outputs.
  logic [NSRC-1:0] h1 = '0, h2 = '0, h3 = '0;
  logic [NSRC-1:0] m_pend = '0, m_mask = '0;
  logic            m_ack = 1'b0;
  logic            e_sys = 1'b0;
  logic            started = 1'b0;
  logic [NSRC-1:0] cur_irq = '0;

  function automatic logic [31:0] ref_vec(input logic [NSRC-1:0] p, input logic [NSRC-1:0] m);
    for (int i = 0; i < NSRC; i++) begin
      if (p[i] && m[i]) return 32'h8000_0000 | 32'(i);
    end
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
    end
  endtask

  task automatic model_step();
    logic        x;
    logic [NSRC-1:0] edges, clr;
    exp_t e;
    if (!grst) begin
      m_pend = '0; m_mask = '0; m_ack = 1'b0; e_sys = 1'b0;
      h1 = '0; h2 = '0; h3 = '0;
      return;
    end
    edges = h2 & ~h3;
    x     = stb & ~m_ack;
    clr   = '0;
    if (x) begin
      e.is_rd = !we;
      case (adr)
        2'd0:    e.data = 32'(m_pend);
        2'd1:    e.data = 32'(m_mask);
        2'd3:    e.data = ref_vec(m_pend, m_mask);
        default: e.data = 32'h0;
      endcase
      sbq.push_back(e);
    end
    e_sys = |(m_pend & m_mask);
    if (x && we && adr == 2'd2) clr = dati[NSRC-1:0];
    if (x && we && adr == 2'd1) m_mask = dati[NSRC-1:0];
    m_pend = (m_pend & ~clr) | edges;
    m_ack  = x;
    h3 = h2; h2 = h1; h1 = irq;
  endtask

  task automatic cyc(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [NSRC-1:0] q, input logic r);
    stb = s; we = w; adr = a; dati = d; irq = q; grst = r;
    @(posedge gclk);
    model_step();
    started = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 32'h0, cur_irq, 1'b1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d, cur_irq, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 32'h0, cur_irq, 1'b1);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b1, 1'b0, a, 32'h0, cur_irq, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 32'h0, cur_irq, 1'b1);
  endtask

  always @(negedge gclk) begin
    if (started) begin
      check("ack", 32'(ack), 32'(m_ack));
      check("sys_int", 32'(sys_int), 32'(e_sys));
      if (m_ack) begin
        if (sbq.size() == 0) begin
          check("sb_underflow", 32'(sbq.size()), 32'd1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (e.is_rd) check("rdata", dato, e.data);
        end
      end else begin
        check("dat_idle", dato, 32'h0);
      end
    end
  end

  initial begin
    // Reset held with sources toggling, then released with all sources low.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'd0, 32'h0, NSRC'($urandom), 1'b0);
    cur_irq = '0;
    idle(4);
    rd(2'd0); rd(2'd1); rd(2'd3);

    // Single source.
    wr(2'd1, 32'h01);
    cur_irq = 8'h01; idle(2);
    cur_irq = 8'h00; idle(3);
    rd(2'd0); rd(2'd3);
    wr(2'd2, 32'h01); idle(1);
    rd(2'd0);

    // Masked recording.
    wr(2'd1, 32'h00);
    cur_irq = 8'h20; idle(2);
    cur_irq = 8'h00; idle(4);
    rd(2'd0);
    wr(2'd1, 32'h20); idle(1);
    rd(2'd3);

    // Priority.
    wr(2'd2, 32'hFF);
    wr(2'd1, 32'hFF);
    cur_irq = 8'h48; idle(2);
    cur_irq = 8'h00; idle(4);
    rd(2'd3);
    wr(2'd2, 32'h08);
    rd(2'd3);

    // Set/clear collision on bit 2.
    wr(2'd2, 32'hFF);
    cur_irq = 8'h04; idle(2);
    cur_irq = 8'h00; idle(4);
    cur_irq = 8'h04;
    idle(2);
    cyc(1'b1, 1'b1, 2'd2, 32'h04, cur_irq, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 32'h0, cur_irq, 1'b1);
    cur_irq = 8'h00; idle(3);
    rd(2'd0); rd(2'd3);

    // Held strobe: six cycles, three acks.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 2'd0, 32'h0, cur_irq, 1'b1);
    idle(1);

    // Reset during a pending write.
    wr(2'd1, 32'hFF);
    cyc(1'b1, 1'b1, 2'd1, 32'h55, cur_irq, 1'b0);
    idle(2);
    rd(2'd1); rd(2'd0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) cur_irq = NSRC'($urandom);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 2'($urandom),
          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
          cur_irq, $urandom_range(0, 99) != 0);
    end
    cur_irq = '0;
    idle(4);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aemb_intc.md
# aemb_intc

Interrupt controller that merges up to 32 external interrupt sources into the single level-sensitive interrupt input of the AEMB core. It sits between peripheral interrupt lines and the core's interrupt pin. It synchronises and edge-detects each source and latches pending events. It applies a software-programmed enable mask, drives one registered interrupt level, and exposes status, mask, acknowledge and vector registers over a Wishbone slave on the data bus.

## Interface
Parameters:
- NSRC, 8, number of interrupt sources (1..32); unused register bits read 0.

Ports:
- gclk  in  1  system clock; all state on rising edge.
- grst  in  1  reset, **synchronous, active-low**.
- irq_i  in  NSRC  asynchronous interrupt sources, rising-edge significant.
- sys_int_o  out  1  interrupt level to core; high while any enabled pending bit is set.
- wb_stb_i  in  1  Wishbone strobe/cycle.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  2  word address: 0 STAT, 1 MASK, 2 ACK, 3 VEC.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid while wb_ack_o is high.
- wb_ack_o  out  1  transfer acknowledge.

## Operation
- Synchroniser: two flops per source (rSYN1, rSYN2), then a history flop rPREV. An edge is `rSYN2 & !rPREV`.
- Pending register rPEND[NSRC-1:0]:
  - Each bit is set by its edge.
  - Each bit is cleared by a write to ACK with a 1 in that bit position.
  - Edges are recorded regardless of the mask.
- Simultaneous edge and ACK clear on the same bit in the same cycle: set wins, so the event is not lost.
- Mask register rMASK: read/write. A 1 enables the source.
- sys_int_o is a registered copy of `|(rPEND & rMASK)`.
- Priority: the lowest index has the highest priority.
- Register map:
  - STAT (0): read only; returns rPEND. Writes are ignored.
  - MASK (1): read/write.
  - ACK (2): write-1-to-clear rPEND; reads return 0.
  - VEC (3): read only. Bit 31 = any enabled pending bit. Bits [4:0] = index of the highest-priority enabled pending source. When none is pending, the read returns 0x00000000.
- VEC is computed from the rPEND and rMASK values in the cycle the read is acknowledged.
- Wishbone protocol:
  - Single-cycle registered ack: `wb_ack_o <= wb_stb_i & !wb_ack_o`.
  - A held strobe therefore gets ack on alternate cycles. Each ack completes exactly one transfer.
  - Writes commit in the cycle wb_ack_o is driven high, so one write performs exactly one update.
  - wb_dat_o is registered alongside ack. It is 0 whenever wb_ack_o is low.
- Reset (grst low at a clock edge) clears: synchronisers, rPREV, rPEND, rMASK, sys_int_o, wb_ack_o and wb_dat_o, all to 0.
  - Reset mid-transfer aborts the transfer with no register update and no ack.
  - A source already high when reset is released produces one edge (rPREV resets to 0).

## Timing
- Edge latency: irq_i rising and meeting setup at edge 0 gives rSYN2 high after edge 1. rPEND is set at edge 2. sys_int_o goes high at edge 3, when enabled.
- An irq_i pulse must stay high for at least 2 gclk cycles to be captured reliably. Shorter pulses may be lost.
- Mask write acknowledged at edge N: rMASK updates at N. sys_int_o reflects it at N+1.
- ACK write acknowledged at edge N: rPEND clears at N. sys_int_o falls at N+1 if nothing else is enabled and pending.
- Read: strobe sampled at edge N gives wb_ack_o and wb_dat_o valid after N, for one cycle.
- Throughput: one transfer every 2 cycles with strobe held.
- sys_int_o remains high until software acknowledges. This satisfies the core's level latch, which samples only while interrupts are enabled.

## Test plan
- Reset check: hold grst=0 with irq_i toggling, then release with all sources low → all outputs 0. STAT, MASK and VEC read 0.
- Single source: write MASK=0x01. Raise irq_i[0] for 2 cycles → STAT=0x01 and VEC=0x80000000. sys_int_o rises 3 edges after irq_i. Write ACK=0x01 → sys_int_o falls the next cycle and STAT=0.
- Masked recording: MASK=0, pulse irq_i[5] → STAT=0x20 and sys_int_o stays 0. Write MASK=0x20 → sys_int_o high 1 cycle later; VEC=0x80000005.
- Priority: MASK=0xFF, pulse sources 6 and 3 together → VEC=0x80000003. Write ACK=0x08 → VEC=0x80000006.
- Set/clear collision: align the irq_i[2] edge reaching rPEND with an ACK=0x04 write ack → bit 2 remains set and sys_int_o stays high.
- Bus protocol: hold wb_stb_i high 6 cycles reading STAT → exactly 3 single-cycle acks. Assert grst during a pending write → no update and no ack.
